// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    localparam int unsigned DEF_WIDTH = 5;
    localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit full adder used as the single arithmetic cell of the serial unit.
module addsub_bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {1'b0, cin_i};

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one bit per clock, LSB first,
// with registered S/C/V that only change on completion.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Op,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int unsigned KW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic             op_q, op_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sum_bit;
    logic             cout;

    addsub_bit_cell u_cell (
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .cin_i  (cy_q),
        .s_o    (sum_bit),
        .cout_o (cout)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            r_sr_q  <= '0;
            op_q    <= 1'b0;
            cy_q    <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            r_sr_q  <= r_sr_d;
            op_q    <= op_d;
            cy_q    <= cy_d;
            s_q     <= s_d;
            c_q     <= c_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        r_sr_d  = r_sr_q;
        op_d    = op_q;
        cy_d    = cy_q;
        s_d     = s_q;
        c_d     = c_q;
        v_d     = v_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B here, seed carry with Op.
                    a_sr_d  = A;
                    b_sr_d  = B ^ {WIDTH{Op}};
                    op_d    = Op;
                    cy_d    = Op;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                r_sr_d = {sum_bit, r_sr_q[WIDTH-1:1]};
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                cy_d   = cout;
                k_d    = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    // cy_q is the carry into the MSB; differing from cout flags signed overflow.
                    s_d     = {sum_bit, r_sr_q[WIDTH-1:1]};
                    c_d     = cout ^ op_q;
                    v_d     = cout ^ cy_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    k_d     = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign S    = s_q;
    assign C    = c_q;
    assign V    = v_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
